// File: rtl/stepper_pkg.sv
// stepper_pkg: shared state encoding, direction constants and default widths for the step planner.
package stepper_pkg;
    typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_t;
    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;
    localparam int DEF_STEP_W = 16;
    localparam int DEF_PER_W  = 16;
    localparam int DEF_POS_W  = 24;
endpackage

// File: rtl/stepper_step_timer.sv
// stepper_step_timer: loadable period down-counter; expire is high while an armed count sits at zero.
module stepper_step_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_low,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] value,
    output logic         expire
);
    logic [W-1:0] cnt;
    logic         run;

    assign expire = run && (cnt == '0);

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (clear) begin
            run <= 1'b0;
        end else if (load) begin
            cnt <= value;
            run <= 1'b1;
        end else if (expire) begin
            run <= 1'b0;
        end else if (run) begin
            cnt <= cnt - W'(1);
        end
    end
endmodule

// File: rtl/stepper_step_planner.sv
// stepper_step_planner: trapezoidal step-rate planner; issues step strobes and tracks signed position.
module stepper_step_planner
    import stepper_pkg::*;
#(
    parameter int STEP_W       = DEF_STEP_W,
    parameter int PER_W        = DEF_PER_W,
    parameter int POS_W        = DEF_POS_W,
    parameter int START_PERIOD = 1000,
    parameter int RAMP_DEC     = 10,
    parameter int MIN_PERIOD   = 50
) (
    input  logic              clk,
    input  logic              reset_low,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [PER_W-1:0]  cmd_period,
    input  logic              abort,
    input  logic              hold_enable,
    output logic              step_pulse,
    output logic              direction,
    output logic              motor_enable,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [POS_W-1:0]  position
);
    localparam int PW1 = PER_W + 1;
    localparam logic [PER_W-1:0] START_P = PER_W'(START_PERIOD);
    localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_PERIOD);
    localparam logic [PER_W-1:0] RAMP_P  = PER_W'(RAMP_DEC);

    state_t            state, nxt_state;
    logic [STEP_W-1:0] remaining, accel_cnt, rem_next, nxt_accel;
    logic [PER_W-1:0]  cur_period, target, cur_up, cur_dn, nxt_period, t_lo, t_clamp, load_value;
    logic [PER_W:0]    up_sum;
    logic              accept, expire, fin, dec, acc, load, clear;

    assign busy         = state != IDLE;
    assign cmd_ready    = (state == IDLE) && !abort;
    assign motor_enable = busy || hold_enable;
    assign accept       = cmd_valid && cmd_ready;
    // abort beats a coincident expiry, so the strobe is masked combinationally
    assign step_pulse   = busy && expire && !abort;

    always_comb begin
        t_lo      = cmd_period < MIN_P ? MIN_P : cmd_period;
        t_clamp   = t_lo > START_P ? START_P : t_lo;
        rem_next  = remaining - STEP_W'(1);
        up_sum    = {1'b0, cur_period} + PW1'(RAMP_DEC);
        cur_up    = up_sum > PW1'(START_PERIOD) ? START_P : up_sum[PER_W-1:0];
        cur_dn    = ({1'b0, cur_period} > {1'b0, target} + PW1'(RAMP_DEC)) ? cur_period - RAMP_P : target;
        fin       = rem_next == '0;
        dec       = rem_next <= accel_cnt;
        acc       = cur_period > target;
        nxt_state = fin ? IDLE : dec ? DECEL : acc ? ACCEL : CRUISE;
        nxt_period = dec ? cur_up : acc ? cur_dn : cur_period;
        nxt_accel = (!dec && acc && accel_cnt != '1) ? accel_cnt + STEP_W'(1) : accel_cnt;
        load      = (accept && cmd_steps != '0) || (step_pulse && !fin);
        clear     = (busy && abort) || (step_pulse && fin);
        load_value = accept ? PER_W'(START_PERIOD - 1) : nxt_period - PER_W'(1);
    end

    stepper_step_timer #(.W(PER_W)) u_timer (
        .clk       (clk),
        .reset_low (reset_low),
        .load      (load),
        .clear     (clear),
        .value     (load_value),
        .expire    (expire)
    );

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state      <= IDLE;
            direction  <= DIR_CW;
            remaining  <= '0;
            accel_cnt  <= '0;
            cur_period <= '0;
            target     <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            position   <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (accept) begin
                direction  <= cmd_dir;
                remaining  <= cmd_steps;
                accel_cnt  <= '0;
                cur_period <= START_P;
                target     <= t_clamp;
                if (cmd_steps == '0) done <= 1'b1;
                else state <= ACCEL;
            end else if (busy && abort) begin
                state   <= IDLE;
                aborted <= 1'b1;
            end else if (step_pulse) begin
                remaining  <= rem_next;
                position   <= position + (direction == DIR_CCW ? '1 : POS_W'(1));
                state      <= nxt_state;
                cur_period <= nxt_period;
                accel_cnt  <= nxt_accel;
                done       <= fin;
            end
        end
    end
endmodule

// File: tb/tb_stepper_step_planner.sv
// tb_stepper_step_planner: directed scenario checks of the step planner with a short ramp.
module tb_stepper_step_planner;
    logic        clk = 1'b0;
    logic        reset_low = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [15:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        hold_enable = 1'b0;
    logic        step_pulse, direction, motor_enable, busy, done, aborted;
    logic [23:0] position;

    int total = 0;
    int bad = 0;
    logic [63:0] pmask;
    int done_c, ab_c, blow_c, ready_at_poke, busy_seen, ready_all, done_cnt;
    logic [23:0] pos0;

    stepper_step_planner #(
        .STEP_W(16), .PER_W(16), .POS_W(24),
        .START_PERIOD(8), .RAMP_DEC(2), .MIN_PERIOD(2)
    ) dut (
        .clk(clk), .reset_low(reset_low), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
        .hold_enable(hold_enable), .step_pulse(step_pulse), .direction(direction),
        .motor_enable(motor_enable), .busy(busy), .done(done), .aborted(aborted),
        .position(position)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] b(input int n);
        return 64'd1 << n;
    endfunction

    function automatic int delta();
        return int'($signed(position - pos0));
    endfunction

    // Cycle c is the interval sampled by the c-th edge after the accepting edge.
    task automatic run_move(input logic dir, input int steps, input int per,
                            input int abort_c, input int poke_c, input int max_c);
        @(negedge clk);
        pos0 = position;
        cmd_dir = dir; cmd_steps = 16'(steps); cmd_period = 16'(per); cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        pmask = '0; done_c = -1; ab_c = -1; blow_c = -1; ready_at_poke = -1;
        busy_seen = 0; ready_all = 1; done_cnt = 0;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clk);
            abort = (c == abort_c);
            cmd_valid = (c == poke_c);
            #1;
            if (step_pulse) pmask[c] = 1'b1;
            if (done) begin done_cnt++; if (done_c < 0) done_c = c; end
            if (aborted && ab_c < 0) ab_c = c;
            if (busy) busy_seen = 1;
            if (!cmd_ready && c != abort_c) ready_all = 0;
            if (c == poke_c) ready_at_poke = int'(cmd_ready);
            if (!busy && blow_c < 0) blow_c = c;
            if ((done_c >= 0 || ab_c >= 0) && c >= (done_c > ab_c ? done_c : ab_c) + 3) break;
        end
        abort = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        total++; if (busy !== 1'b0 || step_pulse !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin bad++; $display("FAIL reset_ctrl busy=%b pulse=%b done=%b aborted=%b want 0", busy, step_pulse, done, aborted); end
        total++; if (position !== 24'd0 || direction !== 1'b0) begin bad++; $display("FAIL reset_pos pos=%0d dir=%b want 0/0", position, direction); end
        @(negedge clk); reset_low = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want 1", cmd_ready); end
        hold_enable = 1'b1; #1;
        total++; if (motor_enable !== 1'b1) begin bad++; $display("FAIL hold_enable got=%b want 1", motor_enable); end
        hold_enable = 1'b0; #1;
        total++; if (motor_enable !== 1'b0) begin bad++; $display("FAIL idle_enable got=%b want 0", motor_enable); end
    endtask

    task automatic test_trapezoid();
        run_move(1'b0, 6, 4, -1, -1, 50);
        total++; if (pmask !== (b(8)|b(14)|b(18)|b(22)|b(28)|b(36))) begin bad++; $display("FAIL trap_pulses got=%h want %h", pmask, b(8)|b(14)|b(18)|b(22)|b(28)|b(36)); end
        total++; if (done_c !== 37 || done_cnt !== 1) begin bad++; $display("FAIL trap_done got=%0d cnt=%0d want 37/1", done_c, done_cnt); end
        total++; if (blow_c !== 37) begin bad++; $display("FAIL trap_busy_low got=%0d want 37", blow_c); end
        total++; if (delta() !== 6) begin bad++; $display("FAIL trap_pos got=%0d want 6", delta()); end
    endtask

    task automatic test_short_ccw();
        run_move(1'b1, 3, 2, -1, -1, 40);
        total++; if (pmask !== (b(8)|b(14)|b(22))) begin bad++; $display("FAIL short_pulses got=%h want %h", pmask, b(8)|b(14)|b(22)); end
        total++; if (done_c !== 23) begin bad++; $display("FAIL short_done got=%0d want 23", done_c); end
        total++; if (delta() !== -3) begin bad++; $display("FAIL short_pos got=%0d want -3", delta()); end
        total++; if (direction !== 1'b1) begin bad++; $display("FAIL dir_hold got=%b want 1", direction); end
    endtask

    task automatic test_zero_steps();
        run_move(1'b0, 0, 4, -1, -1, 10);
        total++; if (pmask !== 64'd0 || busy_seen !== 0) begin bad++; $display("FAIL zero_activity pulses=%h busy_seen=%0d want 0/0", pmask, busy_seen); end
        total++; if (done_c !== 1 || done_cnt !== 1) begin bad++; $display("FAIL zero_done got=%0d cnt=%0d want 1/1", done_c, done_cnt); end
        total++; if (ready_all !== 1) begin bad++; $display("FAIL zero_ready got=%0d want 1", ready_all); end
        total++; if (direction !== 1'b0) begin bad++; $display("FAIL zero_dir got=%b want 0", direction); end
    endtask

    task automatic test_abort();
        run_move(1'b0, 6, 4, 14, -1, 40);
        total++; if (pmask !== b(8)) begin bad++; $display("FAIL abort_pulses got=%h want %h", pmask, b(8)); end
        total++; if (ab_c !== 15 || done_c !== -1) begin bad++; $display("FAIL abort_flags aborted=%0d done=%0d want 15/-1", ab_c, done_c); end
        total++; if (delta() !== 1 || busy !== 1'b0) begin bad++; $display("FAIL abort_pos pos=%0d busy=%b want 1/0", delta(), busy); end
        @(negedge clk); abort = 1'b1; #1;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL idle_abort_ready got=%b want 0", cmd_ready); end
        @(negedge clk); abort = 1'b0; #1;
        total++; if (aborted !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_abort aborted=%b busy=%b ready=%b want 0/0/1", aborted, busy, cmd_ready); end
    endtask

    task automatic test_clamp();
        run_move(1'b0, 3, 20, -1, -1, 40);
        total++; if (pmask !== (b(8)|b(16)|b(24))) begin bad++; $display("FAIL clamp_hi_pulses got=%h want %h", pmask, b(8)|b(16)|b(24)); end
        total++; if (done_c !== 25) begin bad++; $display("FAIL clamp_hi_done got=%0d want 25", done_c); end
        run_move(1'b0, 8, 1, -1, -1, 60);
        total++; if (pmask !== (b(8)|b(14)|b(18)|b(20)|b(22)|b(26)|b(32)|b(40))) begin bad++; $display("FAIL clamp_lo_pulses got=%h want %h", pmask, b(8)|b(14)|b(18)|b(20)|b(22)|b(26)|b(32)|b(40)); end
        total++; if (done_c !== 41 || delta() !== 8) begin bad++; $display("FAIL clamp_lo_done done=%0d pos=%0d want 41/8", done_c, delta()); end
    endtask

    task automatic test_back_to_back();
        run_move(1'b1, 6, 4, -1, 3, 10);
        total++; if (ready_at_poke !== 0) begin bad++; $display("FAIL busy_ready got=%0d want 0", ready_at_poke); end
        total++; if (pmask !== b(8) || delta() !== -1) begin bad++; $display("FAIL mid_move pulses=%h pos=%0d want %h/-1", pmask, delta(), b(8)); end
        #2 reset_low = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || step_pulse !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin bad++; $display("FAIL async_reset busy=%b pulse=%b done=%b aborted=%b want 0", busy, step_pulse, done, aborted); end
        total++; if (position !== 24'd0 || direction !== 1'b0) begin bad++; $display("FAIL async_reset_pos pos=%0d dir=%b want 0/0", position, direction); end
        @(negedge clk); reset_low = 1'b1;
        run_move(1'b0, 2, 20, -1, -1, 30);
        total++; if (pmask !== (b(8)|b(16)) || done_c !== 17) begin bad++; $display("FAIL post_reset pulses=%h done=%0d want %h/17", pmask, done_c, b(8)|b(16)); end
        total++; if (position !== 24'd2) begin bad++; $display("FAIL post_reset_pos got=%0d want 2", position); end
        run_move(1'b0, 2, 20, -1, 3, 40);
        total++; if (pmask !== (b(8)|b(16)) || done_cnt !== 1 || busy !== 1'b0) begin bad++; $display("FAIL ignored_cmd pulses=%h dones=%0d busy=%b want %h/1/0", pmask, done_cnt, busy, b(8)|b(16)); end
    endtask

    initial begin
        test_reset();
        test_trapezoid();
        test_short_ccw();
        test_zero_steps();
        test_abort();
        test_clamp();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
